divider_seq: RTL and testbench
==============================

Name: divider_seq

Overview:
- Iterative radix-2 restoring divider for the RISC5 execute stage.
- Sits beside the multiplier and uses the same run/stall handshake.
- Its quotient and remainder feed the ALU result mux; the remainder also feeds the H register write path.
- Supports unsigned division and signed Euclidean division; one quotient bit is produced per clock.

Parameters:
W, 32, operand width; quotient and remainder are also W bits.

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  reset, asynchronous, active-high
run  in  1  divide request; held high by the CPU while stall=1
u  in  1  1 = unsigned; 0 = signed two's-complement Euclidean
x  in  W  dividend, sampled only on the IDLE->BUSY transition
y  in  W  divisor, sampled only on the IDLE->BUSY transition
stall  out  1  combinational: run & (state != DONE)
quot  out  W  registered quotient
rem  out  W  registered remainder

Behaviour:
- Reset (rst=1, async): state=IDLE, count=0, quot=0, rem=0, internal registers cleared. stall is then low unless run=1.
- States: IDLE, BUSY, DONE.
- IDLE, run=1:
  - Latch u, x, y.
  - Form magnitudes |x| and |y|; apply abs only when u=0.
  - Clear the partial remainder; count=0; go to BUSY.
  - stall=1 in this same cycle.
- BUSY, each cycle:
  - One restoring step: shift {rem_p, dvd} left by 1, trial-subtract |y| from rem_p.
  - If no borrow: keep the difference and set quotient bit 1. Otherwise set quotient bit 0.
  - count increments.
- BUSY, after the step where count reaches W-1:
  - Apply fixup and load quot/rem; go to DONE.
- BUSY, run=0: abort to IDLE; quot/rem are not updated.
- DONE: stall=0; quot/rem stay valid. Stay while run=1; go to IDLE when run=0.
- Latency: run rises in cycle 0 and stall is high in cycles 0..W. Results are valid and stall is low from cycle W+1 (cycle 33 for W=32). Total is W+1 stall cycles.
- Back-to-back divides need run to deassert for at least one cycle (DONE->IDLE).
- Fixup, u=1: quot=q0, rem=r0.
- Fixup, u=0, with q0/r0 the magnitude results:
  - If x<0 and r0!=0: r=|y|-r0 and q1=q0+1. Otherwise r=r0 and q1=q0.
  - quot = (sign(x) xor sign(y)) ? -q1 : q1, truncated to W bits.
  - rem=r, so 0 <= rem < |y|.
- Divide by zero (y=0, either mode): quot = all ones, rem = raw x. The override is applied at fixup.
- Overflow: u=0, x=0x80000000, y=0xFFFFFFFF gives quot=0x80000000 (wrap), rem=0. No flag.
- Operand changes while BUSY or DONE are ignored.
- The abs of 0x80000000 is the unsigned value 2^31; the datapath is W+1 bits wide where needed.
- rst asserted mid-BUSY: immediate return to IDLE, outputs zeroed.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - the W default;
  - the count width localparam, $clog2(W);
  - the DIV0 quotient constant (all ones).
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem_p, dividend MSB, divisor.
  - Outputs: next rem_p, quotient bit.
  - Instantiated once in BUSY.

Test Plan:
1. u=1, x=100, y=7, run held high -> stall high for exactly 33 cycles, then quot=14, rem=2, stall=0.
2. u=0, check three sign cases:
   - x=-7, y=2 -> quot=0xFFFFFFFC (-4), rem=1.
   - x=-7, y=-2 -> quot=4, rem=1.
   - x=7, y=-2 -> quot=0xFFFFFFFD (-3), rem=1.
3. Divide by zero:
   - u=0, x=0x12345678, y=0 -> quot=0xFFFFFFFF, rem=0x12345678.
   - u=1, x=0xFFFFFFFF, y=0 -> quot=0xFFFFFFFF, rem=0xFFFFFFFF.
4. Edge cases:
   - u=0, x=0x80000000, y=0xFFFFFFFF -> quot=0x80000000, rem=0.
   - u=1, x=0xFFFFFFFF, y=1 -> quot=0xFFFFFFFF, rem=0.
5. Abort and reset:
   - Complete 100/7. Start 50/3, drop run at cycle 10, then raise run with 9/4 -> quot/rem stay 14/2 during the abort; the final result is 2/1 after 33 stall cycles.
   - rst pulse at cycle 5 of a divide -> quot=rem=0, state IDLE immediately, without waiting for a clock.
6. Back-to-back: 1000/10 then, after a one-cycle run low, 1000/3 -> 100/0 then 333/1. Changing x/y during BUSY has no effect on the result.

Source files
------------

// File: rtl/divider_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  // Default operand width for the execute-stage divider.
  localparam int DIV_W = 32;

  // Width of the iteration counter; it counts 0..W-1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DIV_W);

  // Quotient returned for a zero divisor is all ones.
  localparam logic             DIV0_FILL = 1'b1;
  localparam logic [DIV_W-1:0] DIV0_Q    = {DIV_W{DIV0_FILL}};

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_seq_if.sv
// Run/stall handshake plus operand and result buses between the CPU and the divider.
interface divider_seq_if
  import div_pkg::*;
#(
  parameter int W = DIV_W
);
  logic         run;
  logic         u;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         stall;
  logic [W-1:0] quot;
  logic [W-1:0] rem;

  // CPU side: issues the request and consumes the results.
  modport master (
    output run, u, x, y,
    input  stall, quot, rem
  );

  // Divider side.
  modport slave (
    input  run, u, x, y,
    output stall, quot, rem
  );
endinterface

// File: rtl/divider_seq_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] rem_p,
  input  logic         dvd_msb,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;

  // The shifted partial remainder needs W+1 bits because it can reach 2*|y|-1;
  // whenever the subtraction succeeds the true result is below |y|, so a
  // W-bit modular difference is exact.
  always_comb begin
    shifted  = {rem_p, dvd_msb};
    q_bit    = (shifted >= {1'b0, dvs});
    diff     = shifted[W-1:0] - dvs;
    rem_next = q_bit ? diff : shifted[W-1:0];
  end

endmodule

// File: rtl/divider_seq.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, with
// unsigned and signed Euclidean modes and the CPU run/stall handshake.
module divider_seq
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic          clk,
  input  logic          rst,
  divider_seq_if.slave  bus
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  div_state_t state_reg, state_next;

  logic [CW-1:0] count_reg;
  logic          u_reg;
  logic [W-1:0]  x_reg;       // raw dividend, needed for sign and divide-by-zero result
  logic [W-1:0]  y_reg;       // raw divisor, needed for sign and zero detection
  logic [W-1:0]  dvd_reg;     // dividend magnitude shifting out, quotient shifting in
  logic [W-1:0]  dvs_reg;     // divisor magnitude
  logic [W-1:0]  rem_p_reg;   // partial remainder
  logic [W-1:0]  quot_reg;
  logic [W-1:0]  rem_reg;

  logic          start;
  logic          step_en;
  logic          load_res;

  logic [W-1:0]  rem_step;
  logic          q_bit;

  logic [W-1:0]  x_mag;
  logic [W-1:0]  y_mag;

  logic [W-1:0]  q0;
  logic [W-1:0]  r0;
  logic [W-1:0]  q1;
  logic [W-1:0]  r1;
  logic          adj;
  logic [W-1:0]  fix_q;
  logic [W-1:0]  fix_r;

  // Single step datapath shared by every BUSY cycle.
  div_step #(.W(W)) u_step (
    .rem_p    (rem_p_reg),
    .dvd_msb  (dvd_reg[W-1]),
    .dvs      (dvs_reg),
    .rem_next (rem_step),
    .q_bit    (q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; dropping run while BUSY abandons the divide.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.run) state_next = BUSY;
      BUSY: begin
        if (!bus.run) begin
          state_next = IDLE;
        end else if (count_reg == LAST_CNT) begin
          state_next = DONE;
        end
      end
      DONE: if (!bus.run) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and datapath enables decoded from the current state.
  always_comb begin
    bus.stall = bus.run && (state_reg != DONE);
    start     = (state_reg == IDLE) && bus.run;
    step_en   = (state_reg == BUSY) && bus.run;
    load_res  = step_en && (count_reg == LAST_CNT);
  end

  // Operand magnitudes; abs only in signed mode, and the most negative value
  // maps cleanly to its unsigned magnitude 2^(W-1).
  always_comb begin
    x_mag = (!bus.u && bus.x[W-1]) ? (~bus.x + 1'b1) : bus.x;
    y_mag = (!bus.u && bus.y[W-1]) ? (~bus.y + 1'b1) : bus.y;
  end

  // Sign fixup and divide-by-zero override, evaluated on the final step.
  always_comb begin
    q0    = {dvd_reg[W-2:0], q_bit};
    r0    = rem_step;
    adj   = 1'b0;
    q1    = q0;
    r1    = r0;
    fix_q = q0;
    fix_r = r0;
    if (y_reg == '0) begin
      fix_q = {W{DIV0_FILL}};
      fix_r = x_reg;
    end else if (!u_reg) begin
      // Euclidean: a negative dividend with a nonzero remainder rounds the
      // magnitude quotient up so the remainder stays non-negative.
      adj   = x_reg[W-1] && (r0 != '0);
      q1    = adj ? (q0 + 1'b1) : q0;
      r1    = adj ? (dvs_reg - r0) : r0;
      fix_q = (x_reg[W-1] ^ y_reg[W-1]) ? (~q1 + 1'b1) : q1;
      fix_r = r1;
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      u_reg     <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      rem_p_reg <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
    end else begin
      if (start) begin
        u_reg     <= bus.u;
        x_reg     <= bus.x;
        y_reg     <= bus.y;
        dvd_reg   <= x_mag;
        dvs_reg   <= y_mag;
        rem_p_reg <= '0;
        count_reg <= '0;
      end else if (step_en) begin
        dvd_reg   <= {dvd_reg[W-2:0], q_bit};
        rem_p_reg <= rem_step;
        count_reg <= count_reg + 1'b1;
      end
      if (load_res) begin
        quot_reg <= fix_q;
        rem_reg  <= fix_r;
      end
    end
  end

  // Results are driven straight from their registers.
  always_comb begin
    bus.quot = quot_reg;
    bus.rem  = rem_reg;
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq: expected results go into a scoreboard queue
// when a divide is launched and are popped when the divider releases stall.
module tb_divider_seq;
  import div_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;

  divider_seq_if #(.W(W)) bus ();

  divider_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } res_t;

  res_t sb_q[$];
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch a divide from IDLE (called at posedge+1), count stall cycles with a
  // bound, then compare against the scoreboard and release run for one cycle.
  task automatic do_div(input string tag, input logic mode_u, input logic [W-1:0] xv,
                        input logic [W-1:0] yv, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input bit scramble);
    int   n;
    res_t e;
    sb_q.push_back('{q: eq, r: er});
    bus.u   = mode_u;
    bus.x   = xv;
    bus.y   = yv;
    bus.run = 1'b1;
    #1;
    n = 0;
    while (bus.stall && n < 200) begin
      n++;
      @(posedge clk);
      #1;
      if (scramble && n == 5) begin
        bus.x = $urandom;
        bus.y = $urandom;
        bus.u = ~bus.u;
      end
    end
    e = sb_q.pop_front();
    $display("div %s u=%0d x=%0h y=%0h -> quot=%0h rem=%0h stall_cycles=%0d",
             tag, mode_u, xv, yv, bus.quot, bus.rem, n);
    chk({tag, "_cycles"}, 64'(n), 64'(W + 1));
    chk({tag, "_quot"}, 64'(bus.quot), 64'(e.q));
    chk({tag, "_rem"}, 64'(bus.rem), 64'(e.r));
    chk({tag, "_stall"}, 64'(bus.stall), 64'(0));
    bus.run = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.run = 1'b0;
    bus.u   = 1'b1;
    bus.x   = '0;
    bus.y   = '0;
    #1;
    chk("reset_quot", 64'(bus.quot), 64'(0));
    chk("reset_rem", 64'(bus.rem), 64'(0));
    chk("reset_stall", 64'(bus.stall), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic unsigned divide.
    do_div("u_100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Signed Euclidean sign cases.
    do_div("s_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFC, 32'd1, 1'b0);
    do_div("s_m7_m2", 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd4, 32'd1, 1'b0);
    do_div("s_7_m2", 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);

    // Divide by zero in both modes.
    do_div("s_div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    do_div("u_div0", 1'b1, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Edge cases: signed overflow wraps, unsigned maximum by one.
    do_div("s_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    do_div("u_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Abort: complete 100/7, start 50/3, drop run mid-divide, then run 9/4.
    do_div("u_100_7b", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    bus.u   = 1'b1;
    bus.x   = 32'd50;
    bus.y   = 32'd3;
    bus.run = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.run = 1'b0;
    #1;
    $display("abort in flight: quot=%0h rem=%0h stall=%0d", bus.quot, bus.rem, bus.stall);
    chk("abort_quot_busy", 64'(bus.quot), 64'(14));
    chk("abort_rem_busy", 64'(bus.rem), 64'(2));
    @(posedge clk);
    #1;
    chk("abort_state", 64'(dut.state_reg), 64'(IDLE));
    chk("abort_quot_idle", 64'(bus.quot), 64'(14));
    chk("abort_rem_idle", 64'(bus.rem), 64'(2));
    do_div("u_9_4", 1'b1, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

    // Asynchronous reset five cycles into a divide, between clock edges.
    bus.u   = 1'b1;
    bus.x   = 32'd1000;
    bus.y   = 32'd3;
    bus.run = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    $display("mid-divide reset: quot=%0h rem=%0h state=%0d", bus.quot, bus.rem, dut.state_reg);
    chk("rst_quot", 64'(bus.quot), 64'(0));
    chk("rst_rem", 64'(bus.rem), 64'(0));
    chk("rst_state", 64'(dut.state_reg), 64'(IDLE));
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back divides with a single idle cycle; operands scrambled mid-divide.
    do_div("u_1000_10", 1'b1, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    do_div("u_1000_3", 1'b1, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
